uart_store_configs: RTL and testbench

// - Config receiver behind the UART RX. Parses a fixed-length byte frame into the pulse-generator configuration registers.
// - Stored fields: channel select, A-line select, 32-bit pulse shape, and a 16-bit amplitude table (8 channels x 16 A-lines).
// - Sits between uart_rx (byte + strobe) and the pulse/channel generators; all outputs are held registers.

---
 rtl/uart_store_configs.sv | 108 ++++++++++
 tb/tb_uart_store_configs.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_store_configs.sv
// uart_store_configs: parses a 263-byte UART config frame into channel/A-line/pulse-shape registers and a 8x16 amplitude table.
module uart_store_configs #(
  parameter logic [7:0] START_BYTE = 8'hDF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_data,
  input  logic        new_data,
  output logic        intaking_configs,
  output logic [7:0]  channel_select,
  output logic [4:0]  aline_select,
  output logic [31:0] pulse_shape,
  output logic [15:0] c0a0, c0a1, c0a2, c0a3, c0a4, c0a5, c0a6, c0a7, c0a8, c0a9, c0a10, c0a11, c0a12, c0a13, c0a14, c0a15,
  output logic [15:0] c1a0, c1a1, c1a2, c1a3, c1a4, c1a5, c1a6, c1a7, c1a8, c1a9, c1a10, c1a11, c1a12, c1a13, c1a14, c1a15,
  output logic [15:0] c2a0, c2a1, c2a2, c2a3, c2a4, c2a5, c2a6, c2a7, c2a8, c2a9, c2a10, c2a11, c2a12, c2a13, c2a14, c2a15,
  output logic [15:0] c3a0, c3a1, c3a2, c3a3, c3a4, c3a5, c3a6, c3a7, c3a8, c3a9, c3a10, c3a11, c3a12, c3a13, c3a14, c3a15,
  output logic [15:0] c4a0, c4a1, c4a2, c4a3, c4a4, c4a5, c4a6, c4a7, c4a8, c4a9, c4a10, c4a11, c4a12, c4a13, c4a14, c4a15,
  output logic [15:0] c5a0, c5a1, c5a2, c5a3, c5a4, c5a5, c5a6, c5a7, c5a8, c5a9, c5a10, c5a11, c5a12, c5a13, c5a14, c5a15,
  output logic [15:0] c6a0, c6a1, c6a2, c6a3, c6a4, c6a5, c6a6, c6a7, c6a8, c6a9, c6a10, c6a11, c6a12, c6a13, c6a14, c6a15,
  output logic [15:0] c7a0, c7a1, c7a2, c7a3, c7a4, c7a5, c7a6, c7a7, c7a8, c7a9, c7a10, c7a11, c7a12, c7a13, c7a14, c7a15
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic        nd_q;
  logic        accept;
  logic [7:0]  chan_q, hold_q;
  logic [4:0]  aline_q;
  logic [31:0] shape_q;
  logic [15:0] tbl_q [128];
  logic [6:0]  word;
  assign accept = new_data & ~nd_q;
  // Even idx from 6 up carries a word's MSB byte, odd idx its LSB byte.
  assign word = 7'((idx_q - 9'd6) >> 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept && state_q == IDLE && uart_data == START_BYTE) begin
      state_d = RECV;
      idx_d   = '0;
    end else if (accept && state_q == RECV) begin
      state_d = (idx_q == 9'd261) ? IDLE : RECV;
      idx_d   = (idx_q == 9'd261) ? '0 : idx_q + 9'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nd_q    <= 1'b0;
      chan_q  <= '0;
      aline_q <= '0;
      shape_q <= '0;
      hold_q  <= '0;
      for (int i = 0; i < 128; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nd_q    <= new_data;
      if (accept && state_q == RECV) begin
        if (idx_q == 9'd0) chan_q <= uart_data;
        else if (idx_q == 9'd1) aline_q <= uart_data[4:0];
        else if (idx_q == 9'd2) shape_q[31:24] <= uart_data;
        else if (idx_q == 9'd3) shape_q[23:16] <= uart_data;
        else if (idx_q == 9'd4) shape_q[15:8] <= uart_data;
        else if (idx_q == 9'd5) shape_q[7:0] <= uart_data;
        else if (!idx_q[0]) hold_q <= uart_data;
        else tbl_q[word] <= {hold_q, uart_data};
      end
    end
  end
  assign intaking_configs = (state_q == RECV);
  assign channel_select   = chan_q;
  assign aline_select     = aline_q;
  assign pulse_shape      = shape_q;
  assign c0a0 = tbl_q[0];    assign c0a1 = tbl_q[1];    assign c0a2 = tbl_q[2];    assign c0a3 = tbl_q[3];
  assign c0a4 = tbl_q[4];    assign c0a5 = tbl_q[5];    assign c0a6 = tbl_q[6];    assign c0a7 = tbl_q[7];
  assign c0a8 = tbl_q[8];    assign c0a9 = tbl_q[9];    assign c0a10 = tbl_q[10];  assign c0a11 = tbl_q[11];
  assign c0a12 = tbl_q[12];  assign c0a13 = tbl_q[13];  assign c0a14 = tbl_q[14];  assign c0a15 = tbl_q[15];
  assign c1a0 = tbl_q[16];   assign c1a1 = tbl_q[17];   assign c1a2 = tbl_q[18];   assign c1a3 = tbl_q[19];
  assign c1a4 = tbl_q[20];   assign c1a5 = tbl_q[21];   assign c1a6 = tbl_q[22];   assign c1a7 = tbl_q[23];
  assign c1a8 = tbl_q[24];   assign c1a9 = tbl_q[25];   assign c1a10 = tbl_q[26];  assign c1a11 = tbl_q[27];
  assign c1a12 = tbl_q[28];  assign c1a13 = tbl_q[29];  assign c1a14 = tbl_q[30];  assign c1a15 = tbl_q[31];
  assign c2a0 = tbl_q[32];   assign c2a1 = tbl_q[33];   assign c2a2 = tbl_q[34];   assign c2a3 = tbl_q[35];
  assign c2a4 = tbl_q[36];   assign c2a5 = tbl_q[37];   assign c2a6 = tbl_q[38];   assign c2a7 = tbl_q[39];
  assign c2a8 = tbl_q[40];   assign c2a9 = tbl_q[41];   assign c2a10 = tbl_q[42];  assign c2a11 = tbl_q[43];
  assign c2a12 = tbl_q[44];  assign c2a13 = tbl_q[45];  assign c2a14 = tbl_q[46];  assign c2a15 = tbl_q[47];
  assign c3a0 = tbl_q[48];   assign c3a1 = tbl_q[49];   assign c3a2 = tbl_q[50];   assign c3a3 = tbl_q[51];
  assign c3a4 = tbl_q[52];   assign c3a5 = tbl_q[53];   assign c3a6 = tbl_q[54];   assign c3a7 = tbl_q[55];
  assign c3a8 = tbl_q[56];   assign c3a9 = tbl_q[57];   assign c3a10 = tbl_q[58];  assign c3a11 = tbl_q[59];
  assign c3a12 = tbl_q[60];  assign c3a13 = tbl_q[61];  assign c3a14 = tbl_q[62];  assign c3a15 = tbl_q[63];
  assign c4a0 = tbl_q[64];   assign c4a1 = tbl_q[65];   assign c4a2 = tbl_q[66];   assign c4a3 = tbl_q[67];
  assign c4a4 = tbl_q[68];   assign c4a5 = tbl_q[69];   assign c4a6 = tbl_q[70];   assign c4a7 = tbl_q[71];
  assign c4a8 = tbl_q[72];   assign c4a9 = tbl_q[73];   assign c4a10 = tbl_q[74];  assign c4a11 = tbl_q[75];
  assign c4a12 = tbl_q[76];  assign c4a13 = tbl_q[77];  assign c4a14 = tbl_q[78];  assign c4a15 = tbl_q[79];
  assign c5a0 = tbl_q[80];   assign c5a1 = tbl_q[81];   assign c5a2 = tbl_q[82];   assign c5a3 = tbl_q[83];
  assign c5a4 = tbl_q[84];   assign c5a5 = tbl_q[85];   assign c5a6 = tbl_q[86];   assign c5a7 = tbl_q[87];
  assign c5a8 = tbl_q[88];   assign c5a9 = tbl_q[89];   assign c5a10 = tbl_q[90];  assign c5a11 = tbl_q[91];
  assign c5a12 = tbl_q[92];  assign c5a13 = tbl_q[93];  assign c5a14 = tbl_q[94];  assign c5a15 = tbl_q[95];
  assign c6a0 = tbl_q[96];   assign c6a1 = tbl_q[97];   assign c6a2 = tbl_q[98];   assign c6a3 = tbl_q[99];
  assign c6a4 = tbl_q[100];  assign c6a5 = tbl_q[101];  assign c6a6 = tbl_q[102];  assign c6a7 = tbl_q[103];
  assign c6a8 = tbl_q[104];  assign c6a9 = tbl_q[105];  assign c6a10 = tbl_q[106]; assign c6a11 = tbl_q[107];
  assign c6a12 = tbl_q[108]; assign c6a13 = tbl_q[109]; assign c6a14 = tbl_q[110]; assign c6a15 = tbl_q[111];
  assign c7a0 = tbl_q[112];  assign c7a1 = tbl_q[113];  assign c7a2 = tbl_q[114];  assign c7a3 = tbl_q[115];
  assign c7a4 = tbl_q[116];  assign c7a5 = tbl_q[117];  assign c7a6 = tbl_q[118];  assign c7a7 = tbl_q[119];
  assign c7a8 = tbl_q[120];  assign c7a9 = tbl_q[121];  assign c7a10 = tbl_q[122]; assign c7a11 = tbl_q[123];
  assign c7a12 = tbl_q[124]; assign c7a13 = tbl_q[125]; assign c7a14 = tbl_q[126]; assign c7a15 = tbl_q[127];
endmodule

// File: tb/tb_uart_store_configs.sv
// tb_uart_store_configs: directed frames against hand-computed register contents.
module tb_uart_store_configs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_data = '0;
  logic        new_data = 1'b0;
  logic        intaking_configs;
  logic [7:0]  channel_select;
  logic [4:0]  aline_select;
  logic [31:0] pulse_shape;
  logic [15:0] t [128];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  uart_store_configs dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .new_data(new_data),
    .intaking_configs(intaking_configs), .channel_select(channel_select),
    .aline_select(aline_select), .pulse_shape(pulse_shape),
    .c0a0(t[0]), .c0a1(t[1]), .c0a2(t[2]), .c0a3(t[3]), .c0a4(t[4]), .c0a5(t[5]), .c0a6(t[6]), .c0a7(t[7]),
    .c0a8(t[8]), .c0a9(t[9]), .c0a10(t[10]), .c0a11(t[11]), .c0a12(t[12]), .c0a13(t[13]), .c0a14(t[14]), .c0a15(t[15]),
    .c1a0(t[16]), .c1a1(t[17]), .c1a2(t[18]), .c1a3(t[19]), .c1a4(t[20]), .c1a5(t[21]), .c1a6(t[22]), .c1a7(t[23]),
    .c1a8(t[24]), .c1a9(t[25]), .c1a10(t[26]), .c1a11(t[27]), .c1a12(t[28]), .c1a13(t[29]), .c1a14(t[30]), .c1a15(t[31]),
    .c2a0(t[32]), .c2a1(t[33]), .c2a2(t[34]), .c2a3(t[35]), .c2a4(t[36]), .c2a5(t[37]), .c2a6(t[38]), .c2a7(t[39]),
    .c2a8(t[40]), .c2a9(t[41]), .c2a10(t[42]), .c2a11(t[43]), .c2a12(t[44]), .c2a13(t[45]), .c2a14(t[46]), .c2a15(t[47]),
    .c3a0(t[48]), .c3a1(t[49]), .c3a2(t[50]), .c3a3(t[51]), .c3a4(t[52]), .c3a5(t[53]), .c3a6(t[54]), .c3a7(t[55]),
    .c3a8(t[56]), .c3a9(t[57]), .c3a10(t[58]), .c3a11(t[59]), .c3a12(t[60]), .c3a13(t[61]), .c3a14(t[62]), .c3a15(t[63]),
    .c4a0(t[64]), .c4a1(t[65]), .c4a2(t[66]), .c4a3(t[67]), .c4a4(t[68]), .c4a5(t[69]), .c4a6(t[70]), .c4a7(t[71]),
    .c4a8(t[72]), .c4a9(t[73]), .c4a10(t[74]), .c4a11(t[75]), .c4a12(t[76]), .c4a13(t[77]), .c4a14(t[78]), .c4a15(t[79]),
    .c5a0(t[80]), .c5a1(t[81]), .c5a2(t[82]), .c5a3(t[83]), .c5a4(t[84]), .c5a5(t[85]), .c5a6(t[86]), .c5a7(t[87]),
    .c5a8(t[88]), .c5a9(t[89]), .c5a10(t[90]), .c5a11(t[91]), .c5a12(t[92]), .c5a13(t[93]), .c5a14(t[94]), .c5a15(t[95]),
    .c6a0(t[96]), .c6a1(t[97]), .c6a2(t[98]), .c6a3(t[99]), .c6a4(t[100]), .c6a5(t[101]), .c6a6(t[102]), .c6a7(t[103]),
    .c6a8(t[104]), .c6a9(t[105]), .c6a10(t[106]), .c6a11(t[107]), .c6a12(t[108]), .c6a13(t[109]), .c6a14(t[110]), .c6a15(t[111]),
    .c7a0(t[112]), .c7a1(t[113]), .c7a2(t[114]), .c7a3(t[115]), .c7a4(t[116]), .c7a5(t[117]), .c7a6(t[118]), .c7a7(t[119]),
    .c7a8(t[120]), .c7a9(t[121]), .c7a10(t[122]), .c7a11(t[123]), .c7a12(t[124]), .c7a13(t[125]), .c7a14(t[126]), .c7a15(t[127])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic [7:0] b, input int len);
    @(negedge clk);
    uart_data = b;
    new_data = 1'b1;
    repeat (len) @(negedge clk);
    new_data = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    pulse(b, 1);
  endtask
  task automatic check_all_zero(input string tag);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 128; i++) acc = acc | t[i];
    check({tag, "_tbl"}, {16'h0, acc}, 32'h0);
    check({tag, "_ch"}, {24'h0, channel_select}, 32'h0);
    check({tag, "_al"}, {27'h0, aline_select}, 32'h0);
    check({tag, "_ps"}, pulse_shape, 32'h0);
    check({tag, "_busy"}, {31'h0, intaking_configs}, 32'h0);
  endtask
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");
    // Held DF pulses: one start byte, then three data bytes.
    for (int p = 0; p < 4; p++) pulse(8'hDF, 5);
    @(negedge clk);
    check("dfp_busy", {31'h0, intaking_configs}, 32'h1);
    check("dfp_ch", {24'h0, channel_select}, 32'hDF);
    check("dfp_al", {27'h0, aline_select}, 32'h1F);
    check("dfp_ps", pulse_shape, 32'hDF000000);
    do_reset(1);
    check_all_zero("rst2");
    send(8'hDF);
    send(8'h0F); send(8'h03); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    for (int w = 0; w < 128; w++) begin
      send(8'hA0);
      if (w == 127) begin
        @(negedge clk);
        check("busy_before_last", {31'h0, intaking_configs}, 32'h1);
      end
      send(8'(w));
    end
    @(negedge clk);
    check("full_busy_end", {31'h0, intaking_configs}, 32'h0);
    check("full_ch", {24'h0, channel_select}, 32'h0F);
    check("full_al", {27'h0, aline_select}, 32'h03);
    check("full_ps", pulse_shape, 32'h12345678);
    check("c0a0", {16'h0, t[0]}, 32'hA000);
    check("c3a5", {16'h0, t[53]}, 32'hA035);
    check("c7a15", {16'h0, t[127]}, 32'hA07F);
    for (int w = 0; w < 128; w++) check($sformatf("tbl%0d", w), {16'h0, t[w]}, 32'hA000 + 32'(w));
    send(8'h55); send(8'h01);
    @(negedge clk);
    check("idle_busy", {31'h0, intaking_configs}, 32'h0);
    check("idle_ch", {24'h0, channel_select}, 32'h0F);
    check("idle_al", {27'h0, aline_select}, 32'h03);
    check("idle_c0a0", {16'h0, t[0]}, 32'hA000);
    // Abort after 10 payload bytes; 0xDF at idx 2 is data.
    send(8'hDF);
    send(8'h11); send(8'h04); send(8'hDF); send(8'hFE); send(8'hBA); send(8'hBE);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    @(negedge clk);
    check("ab_busy", {31'h0, intaking_configs}, 32'h1);
    check("ab_ch", {24'h0, channel_select}, 32'h11);
    check("ab_ps", pulse_shape, 32'hDFFEBABE);
    check("ab_c0a1", {16'h0, t[1]}, 32'h7788);
    check("ab_c0a2", {16'h0, t[2]}, 32'hA002);
    do_reset(1);
    check_all_zero("midrst");
    send(8'hDF); send(8'hAB);
    @(negedge clk);
    check("restart_ch", {24'h0, channel_select}, 32'hAB);
    check("restart_busy", {31'h0, intaking_configs}, 32'h1);
    do_reset(1);
    send(8'hDF);
    pulse(8'h77, 1000);
    @(negedge clk);
    check("held_ch", {24'h0, channel_select}, 32'h77);
    check("held_al", {27'h0, aline_select}, 32'h0);
    send(8'h22);
    @(negedge clk);
    check("held_next_al", {27'h0, aline_select}, 32'h02);
    check("held_next_ch", {24'h0, channel_select}, 32'h77);
    check("held_next_ps", pulse_shape, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
